// File: rtl/multi_port_mem_arbiter_pkg.sv
// Shared constants and sizing helpers for the multi-port memory arbiter.
package multi_port_mem_arbiter_pkg;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Port IDs need at least one bit even for degenerate widths.
  function automatic int unsigned port_id_w(input int unsigned n);
    return (n < 2) ? 1 : clog2_f(n);
  endfunction

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return clog2_f(depth) + 1;
  endfunction

  localparam int unsigned DEF_NUM_PORTS       = 2;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned PORT_ID_W           = port_id_w(DEF_NUM_PORTS);
  localparam int unsigned TAG_FIFO_CNT_W      = fifo_cnt_w(DEF_MAX_OUTSTANDING);

endpackage

// File: rtl/multi_port_mem_arbiter_tag_fifo.sv
// In-order FIFO of issuing port IDs; a push into a full FIFO is legal when a pop happens in the same cycle.
module arb_tag_fifo
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 1,
  parameter int unsigned CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ID_W-1:0]  id_i,
  output logic [ID_W-1:0]  head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = clog2_f(DEPTH);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= id_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/multi_port_mem_arbiter.sv
// Round-robin N-port arbiter onto one single-cycle memory port, with in-order read-response routing.
// Optional debug trace of arbiter state when MULTI_PORT_MEM_ARBITER_SCAN_EN is defined.
module multi_port_mem_arbiter
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SCAN_CYCLES_MIN = 0,
  parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_read,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_byte_en,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0]   req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_PORTS-1:0]                req_ready,
  output logic [NUM_PORTS-1:0]                resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     resp_data,
  output logic [NUM_PORTS*ADDRESS_BITS-1:0]   resp_address,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [DATA_WIDTH/8-1:0]             mem_byte_en,
  output logic [ADDRESS_BITS-1:0]             mem_address_in,
  output logic [DATA_WIDTH-1:0]               mem_data_in,
  input  logic                                mem_ready,
  input  logic                                mem_valid,
  input  logic [DATA_WIDTH-1:0]               mem_data_out,
  input  logic [ADDRESS_BITS-1:0]             mem_address_out,
  output logic                                resp_orphan,
  input  logic                                scan
);

  localparam int unsigned PID_W = port_id_w(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = fifo_cnt_w(MAX_OUTSTANDING);

  logic [NUM_PORTS-1:0] pending;
  logic [PID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PID_W-1:0]     cand;
  logic                 cand_vld, cand_is_read, grant_vld;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
  logic [PID_W-1:0]     fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 orphan_q, orphan_d;

  assign pending = req_read | req_write;

  // First pending port at or after rr_ptr; only that port may be granted this cycle.
  always_comb begin
    int unsigned idx;
    cand     = '0;
    cand_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!cand_vld && pending[idx]) begin
        cand_vld = 1'b1;
        cand     = PID_W'(idx);
      end
    end
  end

  // Read+write together is tagged as a read so its response still gets routed.
  assign cand_is_read = req_read[cand];
  assign fifo_pop     = mem_valid && !fifo_empty && !reset;
  assign can_push     = !fifo_full || fifo_pop;
  assign grant_vld    = cand_vld && mem_ready && !reset && (!cand_is_read || can_push);
  assign fifo_push    = grant_vld && cand_is_read;

  always_comb begin
    req_ready      = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byte_en    = '0;
    mem_address_in = '0;
    mem_data_in    = '0;
    rr_ptr_d       = rr_ptr_q;
    if (grant_vld) begin
      req_ready[cand] = 1'b1;
      mem_read        = req_read[cand];
      mem_write       = req_write[cand];
      mem_byte_en     = req_byte_en[cand*BE_W +: BE_W];
      mem_address_in  = req_address[cand*ADDRESS_BITS +: ADDRESS_BITS];
      mem_data_in     = req_data[cand*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr_d        = (cand == PID_W'(NUM_PORTS - 1)) ? '0 : cand + PID_W'(1);
    end
  end

  always_comb begin
    resp_valid   = '0;
    resp_data    = '0;
    resp_address = '0;
    if (fifo_pop) begin
      resp_valid[fifo_head] = 1'b1;
      resp_data             = {NUM_PORTS{mem_data_out}};
      resp_address          = {NUM_PORTS{mem_address_out}};
    end
  end

  assign orphan_d    = orphan_q || (mem_valid && fifo_empty);
  assign resp_orphan = orphan_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (PID_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .id_i    (cand),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef MULTI_PORT_MEM_ARBITER_SCAN_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clock) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (scan && (cycle_q >= SCAN_CYCLES_MIN) && (cycle_q <= SCAN_CYCLES_MAX))
      $display("arb cyc=%0d rr_ptr=%0d grant=%b count=%0d orphan=%b",
               cycle_q, rr_ptr_q, req_ready, fifo_count, orphan_q);
  end
`else
  logic unused_scan;
  assign unused_scan = ^{scan, fifo_count};
`endif

endmodule

// File: tb/tb_multi_port_mem_arbiter.sv
// Directed scoreboard bench for multi_port_mem_arbiter (4 ports, 4 outstanding reads).
module tb_multi_port_mem_arbiter;

  localparam int NP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NP-1:0] req_read, req_write, req_ready, resp_valid;
  logic [NP*4-1:0]  req_byte_en;
  logic [NP*32-1:0] req_address, req_data, resp_data, resp_address;
  logic          mem_read, mem_write, mem_ready, mem_valid, resp_orphan, scan;
  logic [3:0]    mem_byte_en;
  logic [31:0]   mem_address_in, mem_data_in, mem_data_out, mem_address_out;

  typedef struct {
    string        nm;
    logic [3:0]   rdy;
    logic         rd, wr;
    logic [3:0]   be;
    logic [31:0]  addr, data;
    logic [3:0]   rv;
    logic [127:0] rdat, radr;
    logic         orph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   rk = 0;

  always #5 clock = ~clock;

  multi_port_mem_arbiter #(
    .NUM_PORTS       (NP),
    .DATA_WIDTH      (32),
    .ADDRESS_BITS    (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_byte_en     (req_byte_en),
    .req_address     (req_address),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_address    (resp_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_en     (mem_byte_en),
    .mem_address_in  (mem_address_in),
    .mem_data_in     (mem_data_in),
    .mem_ready       (mem_ready),
    .mem_valid       (mem_valid),
    .mem_data_out    (mem_data_out),
    .mem_address_out (mem_address_out),
    .resp_orphan     (resp_orphan),
    .scan            (scan)
  );

  function automatic logic [31:0] addr_of(input int p);
    return 32'h1000_0000 + 32'(p) * 32'h10;
  endfunction

  function automatic logic [31:0] data_of(input int p);
    return 32'hDA7A_0000 + 32'(p);
  endfunction

  function automatic logic [3:0] be_of(input int p);
    case (p)
      0:       return 4'hF;
      1:       return 4'h3;
      2:       return 4'hC;
      default: return 4'h1;
    endcase
  endfunction

  task automatic chk(input string nm, input string f, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the response the DUT must show in that cycle.
  task automatic cyc(input string nm, input logic rst, input logic [3:0] rd, input logic [3:0] wr,
                     input logic mrdy, input logic mval, input int g, input int h, input logic orph);
    exp_t e;
    reset = rst; req_read = rd; req_write = wr; mem_ready = mrdy; mem_valid = mval;
    if (mval) begin
      rk++;
      mem_data_out    = 32'hC0DE_0000 + 32'(rk);
      mem_address_out = 32'hADD0_0000 + 32'(rk);
    end else begin
      mem_data_out    = '0;
      mem_address_out = '0;
    end
    e.nm = nm; e.rdy = '0; e.rd = 1'b0; e.wr = 1'b0; e.be = '0; e.addr = '0; e.data = '0;
    e.rv = '0; e.rdat = '0; e.radr = '0; e.orph = orph;
    if (g >= 0) begin
      e.rdy = 4'b0001 << g; e.rd = rd[g]; e.wr = wr[g];
      e.be = be_of(g); e.addr = addr_of(g); e.data = data_of(g);
    end
    if (h >= 0) begin
      e.rv = 4'b0001 << h;
      e.rdat = {4{32'hC0DE_0000 + 32'(rk)}};
      e.radr = {4{32'hADD0_0000 + 32'(rk)}};
    end
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "req_ready",    128'(req_ready),      128'(e.rdy));
      chk(e.nm, "mem_read",     128'(mem_read),       128'(e.rd));
      chk(e.nm, "mem_write",    128'(mem_write),      128'(e.wr));
      chk(e.nm, "mem_byte_en",  128'(mem_byte_en),    128'(e.be));
      chk(e.nm, "mem_address",  128'(mem_address_in), 128'(e.addr));
      chk(e.nm, "mem_data_in",  128'(mem_data_in),    128'(e.data));
      chk(e.nm, "resp_valid",   128'(resp_valid),     128'(e.rv));
      chk(e.nm, "resp_data",    resp_data,            e.rdat);
      chk(e.nm, "resp_address", resp_address,         e.radr);
      chk(e.nm, "resp_orphan",  128'(resp_orphan),    128'(e.orph));
    end
  end

  initial begin
    reset = 1'b1; scan = 1'b0; req_read = '0; req_write = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_data_out = '0; mem_address_out = '0;
    for (int p = 0; p < NP; p++) begin
      req_address[p*32 +: 32] = addr_of(p);
      req_data[p*32 +: 32]    = data_of(p);
      req_byte_en[p*4 +: 4]   = be_of(p);
    end
    repeat (2) @(posedge clock);
    #1;

    cyc("rst_hold", 1, 4'b0011, 4'b0000, 1, 0, -1, -1, 0);

    // Two readers alternate; each response returns the cycle after its request.
    cyc("alt0",      0, 4'b0011, 4'b0000, 1, 0,  0, -1, 0);
    cyc("alt1",      0, 4'b0011, 4'b0000, 1, 1,  1,  0, 0);
    cyc("alt2",      0, 4'b0011, 4'b0000, 1, 1,  0,  1, 0);
    cyc("alt3",      0, 4'b0011, 4'b0000, 1, 1,  1,  0, 0);
    cyc("alt_drain", 0, 4'b0000, 4'b0000, 1, 1, -1,  1, 0);

    // rr_ptr=2, ports 1 and 3 pending.
    cyc("rr_nordy",  0, 4'b1010, 4'b0000, 0, 0, -1, -1, 0);
    cyc("rr_p3",     0, 4'b1010, 4'b0000, 1, 0,  3, -1, 0);
    cyc("rr_p1",     0, 4'b1010, 4'b0000, 1, 0,  1, -1, 0);
    cyc("rr_back2",  0, 4'b0000, 4'b0110, 1, 0,  2, -1, 0);
    cyc("wr_p1",     0, 4'b0000, 4'b0010, 1, 0,  1, -1, 0);
    cyc("rr_resp3",  0, 4'b0000, 4'b0000, 1, 1, -1,  3, 0);
    cyc("rr_resp1",  0, 4'b0000, 4'b0000, 1, 1, -1,  1, 0);

    // Fill the tag FIFO; the fifth read waits for the first response.
    repeat (4) cyc("fill",       0, 4'b0001, 4'b0000, 1, 0,  0, -1, 0);
    repeat (2) cyc("full_stall", 0, 4'b0001, 4'b0000, 1, 0, -1, -1, 0);
    cyc("full_swap",             0, 4'b0001, 4'b0000, 1, 1,  0,  0, 0);
    cyc("full_hold",             0, 4'b0001, 4'b0000, 1, 0, -1, -1, 0);
    repeat (4) cyc("full_drain", 0, 4'b0000, 4'b0000, 1, 1, -1,  0, 0);

    cyc("orph_set",               0, 4'b0000, 4'b0000, 1, 1, -1, -1, 0);
    repeat (2) cyc("orph_sticky", 0, 4'b0000, 4'b0000, 1, 0, -1, -1, 1);

    // Reset with three reads outstanding.
    repeat (3) cyc("rst_fill", 0, 4'b0001, 4'b0000, 1, 0,  0, -1, 1);
    cyc("rst_apply",           1, 4'b1100, 4'b0000, 1, 0, -1, -1, 1);
    cyc("post_rst_p2",         0, 4'b1100, 4'b0000, 1, 0,  2, -1, 0);
    cyc("post_rst_p3",         0, 4'b1100, 4'b0000, 1, 0,  3, -1, 0);
    cyc("post_resp2",          0, 4'b0000, 4'b0000, 1, 1, -1,  2, 0);
    cyc("post_resp3",          0, 4'b0000, 4'b0000, 1, 1, -1,  3, 0);
    cyc("late_resp",           0, 4'b0000, 4'b0000, 1, 1, -1, -1, 0);
    cyc("late_orph",           0, 4'b0000, 4'b0000, 1, 0, -1, -1, 1);

    reset = 1'b0; req_read = '0; req_write = '0; mem_valid = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clock);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
